// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes and the responder FSM state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ahb_pkg;

  // HTRANS transfer types
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // HRESP response codes
  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  // HSIZE codes this responder understands; anything above WORD is illegal
  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

endpackage

// File: rtl/ahb_xfer_check.sv
// Decodes one AHB address phase into little-endian byte enables and an illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is sampled.
module ahb_xfer_check
  import ahb_pkg::*;
(
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] mem_bytes,
  output logic [3:0]  mem_be,
  output logic        illegal
);

  // Size/alignment decode plus window range check
  always_comb begin
    mem_be  = 4'b0000;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: mem_be = 4'b0001 << haddr[1:0];
      HSIZE_HALF: begin
        mem_be  = 4'b0011 << haddr[1:0];
        illegal = haddr[0];
      end
      HSIZE_WORD: begin
        mem_be  = 4'b1111;
        illegal = |haddr[1:0];
      end
      default: illegal = 1'b1;
    endcase
    if (haddr >= mem_bytes) begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_lite_sdram_slave.sv
// AHB-Lite responder that forwards each legal beat as one req/ack request to the SDRAM scheduler.
// Latency: request issued the cycle after the address phase; bus released the cycle after mem_ack.
// Backpressure: HREADYOUT held low while the request is outstanding and during the first ERROR cycle.
module ahb_lite_sdram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] MEM_BYTES = 32'h0200_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] hrdata_q, hrdata_d;

  logic [3:0]  chk_be;
  logic        chk_illegal;
  logic        xfer_vld;

  // Bursts are handled beat by beat and HTRANS[0] only separates IDLE from BUSY,
  // both of which get the same zero-wait OKAY.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign xfer_vld = HSEL & HTRANS[1] & HREADY;

  ahb_xfer_check u_xfer_check (
    .haddr     (HADDR),
    .hsize     (HSIZE),
    .mem_bytes (MEM_BYTES),
    .mem_be    (chk_be),
    .illegal   (chk_illegal)
  );

  // Next-state, captured address-phase fields and bus/backend outputs
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    hrdata_d  = hrdata_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    mem_req   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (state_q == ST_ERR2) begin
          HRESP = HRESP_ERROR;
        end
        state_d = ST_IDLE;
        if (xfer_vld) begin
          addr_d  = {HADDR[31:2], 2'b00};
          we_d    = HWRITE;
          be_d    = chk_be;
          state_d = chk_illegal ? ST_ERR1 : ST_REQ;
        end
      end
      ST_REQ: begin
        HREADYOUT = 1'b0;
        mem_req   = 1'b1;
        if (mem_ack) begin
          state_d = mem_err ? ST_ERR1 : ST_IDLE;
          if (!we_q) begin
            hrdata_d = mem_rdata;
          end
        end
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; reset also withdraws any outstanding request
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'h0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      hrdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      hrdata_q <= hrdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = HWDATA;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_sdram_slave.sv
// Self-checking bench for ahb_lite_sdram_slave: directed table, corner sequences, random beats.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: bench acts as the SDRAM backend and acks after a chosen number of request cycles.
module tb_ahb_lite_sdram_slave;

  localparam logic [31:0] MEM_BYTES = 32'h0200_0000;
  localparam logic [1:0] TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  always #5 HCLK = ~HCLK;

  ahb_lite_sdram_slave #(.MEM_BYTES(MEM_BYTES)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HTRANS    (HTRANS),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          k;
    bit          berr;
    logic [31:0] rd;
    bit          ill;
    logic [3:0]  be;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  // Reference decode: a beat is legal when sized 1/2/4 bytes, naturally aligned and inside
  // the window; it touches byte lanes [addr%4, addr%4 + nbytes).
  function automatic void model(input logic [31:0] a, input logic [2:0] sz,
                                output bit ill, output logic [3:0] be);
    int nbytes;
    int lo;
    be = 4'h0;
    if (sz > 3'd2) begin
      ill = 1'b1;
      return;
    end
    nbytes = 1 << sz;
    lo = int'(a % 4);
    ill = (a >= MEM_BYTES) || ((a % nbytes) != 0);
    for (int i = 0; i < 4; i++) begin
      be[i] = (i >= lo) && (i < lo + nbytes);
    end
  endfunction

  task automatic drive_addr(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz);
    HSEL   = 1'b1;
    HTRANS = tr;
    HWRITE = wr;
    HADDR  = a;
    HSIZE  = sz;
    HREADY = 1'b1;
    HBURST = 3'($urandom);
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = TR_IDLE;
  endtask

  // One complete transfer starting from a cycle where the responder can sample an address phase.
  task automatic do_xfer(input string tag, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input int k, input bit berr,
                         input logic [31:0] rd, input bit exp_ill, input logic [3:0] exp_be);
    drive_addr(tr, wr, a, sz);
    tick();
    bus_idle();
    HWDATA = wd;
    if (exp_ill) begin
      chk($sformatf("%s decode err1 hreadyout", tag), HREADYOUT, 1'b0);
      chk($sformatf("%s decode err1 hresp", tag), HRESP, 2'b01);
      chk($sformatf("%s decode err1 mem_req", tag), mem_req, 1'b0);
      tick();
      chk($sformatf("%s decode err2 hreadyout", tag), HREADYOUT, 1'b1);
      chk($sformatf("%s decode err2 hresp", tag), HRESP, 2'b01);
      chk($sformatf("%s decode err2 mem_req", tag), mem_req, 1'b0);
    end else begin
      for (int c = 1; c <= k; c++) begin
        chk($sformatf("%s req cyc%0d mem_req", tag, c), mem_req, 1'b1);
        chk($sformatf("%s req cyc%0d hreadyout", tag, c), HREADYOUT, 1'b0);
        if (c == 1) begin
          chk($sformatf("%s mem_addr", tag), mem_addr, {a[31:2], 2'b00});
          chk($sformatf("%s mem_be", tag), mem_be, exp_be);
          chk($sformatf("%s mem_we", tag), mem_we, wr);
          if (wr) chk($sformatf("%s mem_wdata", tag), mem_wdata, wd);
        end
        if (c == k) begin
          mem_ack   = 1'b1;
          mem_err   = berr;
          mem_rdata = rd;
        end
        tick();
      end
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = $urandom;
      if (!wr) last_rd = rd;
      chk($sformatf("%s post-ack mem_req", tag), mem_req, 1'b0);
      if (berr) begin
        chk($sformatf("%s berr err1 hreadyout", tag), HREADYOUT, 1'b0);
        chk($sformatf("%s berr err1 hresp", tag), HRESP, 2'b01);
        tick();
        chk($sformatf("%s berr err2 hreadyout", tag), HREADYOUT, 1'b1);
        chk($sformatf("%s berr err2 hresp", tag), HRESP, 2'b01);
      end else begin
        chk($sformatf("%s done hreadyout", tag), HREADYOUT, 1'b1);
        chk($sformatf("%s done hresp", tag), HRESP, 2'b00);
        chk($sformatf("%s hrdata", tag), HRDATA, last_rd);
      end
    end
  endtask

  task automatic idle_beat(input string tag, input logic [1:0] tr);
    drive_addr(tr, 1'b0, 32'h8, 3'd2);
    tick();
    bus_idle();
    chk($sformatf("%s hreadyout", tag), HREADYOUT, 1'b1);
    chk($sformatf("%s hresp", tag), HRESP, 2'b00);
    chk($sformatf("%s mem_req", tag), mem_req, 1'b0);
  endtask

  initial begin
    bit          ill;
    logic [3:0]  be;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          r;

    HRESET = 1'b1;
    HSEL = 1'b0; HTRANS = TR_IDLE; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd0;
    HBURST = 3'd0; HWDATA = 32'h0; HREADY = 1'b1;
    mem_ack = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0100, 3'd2, 32'hDEADBEEF, 3, 1'b0, 32'h0,        1'b0, 4'b1111};
    vecs[1] = '{1'b0, 32'h0000_0103, 3'd0, 32'h0,        1, 1'b0, 32'hAABBCCDD, 1'b0, 4'b1000};
    vecs[2] = '{1'b0, 32'h0000_0101, 3'd1, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'b0000};
    vecs[3] = '{1'b0, 32'h0200_0000, 3'd2, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'b0000};
    vecs[4] = '{1'b0, 32'h0000_0040, 3'd2, 32'h0,        2, 1'b1, 32'h11112222, 1'b0, 4'b1111};
    vecs[5] = '{1'b1, 32'h0000_0102, 3'd1, 32'hCAFE5A5A, 1, 1'b0, 32'h0,        1'b0, 4'b1100};
    vecs[6] = '{1'b1, 32'h0000_0000, 3'd3, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'b0000};
    vecs[7] = '{1'b0, 32'h01FF_FFFF, 3'd0, 32'h0,        2, 1'b0, 32'h0BADF00D, 1'b0, 4'b1000};
    vecs[8] = '{1'b0, 32'h0000_0002, 3'd2, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'b0000};
    vecs[9] = '{1'b0, 32'h0000_0206, 3'd1, 32'h0,        4, 1'b0, 32'h76543210, 1'b0, 4'b1100};

    tick();
    tick();
    chk("reset hreadyout", HREADYOUT, 1'b1);
    chk("reset hresp", HRESP, 2'b00);
    chk("reset hrdata", HRDATA, 32'h0);
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset mem_we", mem_we, 1'b0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_be", mem_be, 4'h0);
    HRESET = 1'b0;
    tick();

    // Directed table
    foreach (vecs[i]) begin
      do_xfer($sformatf("vec%0d", i), TR_NONSEQ, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd,
              vecs[i].k, vecs[i].berr, vecs[i].rd, vecs[i].ill, vecs[i].be);
    end
    tick();
    chk("after table hresp okay", HRESP, 2'b00);

    // Misaligned halfword, then the bus must drop back to OKAY
    do_xfer("half101", TR_NONSEQ, 1'b0, 32'h101, 3'd1, 32'h0, 1, 1'b0, 32'h0, 1'b1, 4'h0);
    tick();
    chk("half101 back to okay hresp", HRESP, 2'b00);
    chk("half101 back to okay hreadyout", HREADYOUT, 1'b1);

    // Back-to-back NONSEQ/SEQ writes, then BUSY and IDLE beats
    do_xfer("b2b0", TR_NONSEQ, 1'b1, 32'h0, 3'd2, 32'h01020304, 1, 1'b0, 32'h0, 1'b0, 4'hF);
    do_xfer("b2b1", TR_SEQ,    1'b1, 32'h4, 3'd2, 32'h05060708, 1, 1'b0, 32'h0, 1'b0, 4'hF);
    idle_beat("busy beat", TR_BUSY);
    idle_beat("idle beat", TR_IDLE);

    // Address phase with HREADY low must not be sampled
    drive_addr(TR_NONSEQ, 1'b0, 32'h10, 3'd2);
    HREADY = 1'b0;
    tick();
    bus_idle();
    HREADY = 1'b1;
    chk("hready low no mem_req", mem_req, 1'b0);
    chk("hready low hreadyout", HREADYOUT, 1'b1);

    // mem_ack outside a request is ignored
    do_xfer("rd before stray ack", TR_NONSEQ, 1'b0, 32'h20, 3'd2, 32'h0, 2, 1'b0, 32'h13579BDF, 1'b0, 4'hF);
    mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0; mem_err = 1'b0;
    chk("stray ack hreadyout", HREADYOUT, 1'b1);
    chk("stray ack hresp", HRESP, 2'b00);
    chk("stray ack hrdata held", HRDATA, last_rd);
    chk("stray ack mem_req", mem_req, 1'b0);

    // Reset during an outstanding request
    drive_addr(TR_NONSEQ, 1'b1, 32'h200, 3'd2);
    tick();
    bus_idle();
    chk("pre-reset mem_req", mem_req, 1'b1);
    #2 HRESET = 1'b1;
    #1;
    chk("async reset mem_req", mem_req, 1'b0);
    chk("async reset hreadyout", HREADYOUT, 1'b1);
    chk("async reset hresp", HRESP, 2'b00);
    chk("async reset hrdata", HRDATA, 32'h0);
    last_rd = 32'h0;
    tick();
    HRESET = 1'b0;
    tick();
    do_xfer("after reset", TR_NONSEQ, 1'b0, 32'h300, 3'd2, 32'h0, 2, 1'b0, 32'hFEEDFACE, 1'b0, 4'hF);

    // Randomized beats against the reference decode
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom);
      r  = int'($urandom % 8);
      sz = (r < 7) ? 3'(r % 3) : 3'(4 + ($urandom % 4));
      if ($urandom % 8 == 0) a = MEM_BYTES + ($urandom % 4096);
      else                   a = $urandom % MEM_BYTES;
      if (sz <= 3'd2 && ($urandom % 4 != 0)) a = a & ~((32'h1 << sz) - 32'h1);
      model(a, sz, ill, be);
      do_xfer($sformatf("rnd%0d", n), ($urandom % 2) ? TR_SEQ : TR_NONSEQ, wr, a, sz, $urandom,
              int'($urandom_range(1, 4)), ($urandom % 5 == 0), $urandom, ill, be);
      if ($urandom % 4 == 0) idle_beat($sformatf("rnd%0d busy", n), TR_BUSY);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
